fifo_rr_arbiter: RTL and testbench

Round-robin burst scheduler that shares one downstream FIFO between N upstream FIFOs in a router. Each cycle it pops at most one item from the granted upstream FIFO and pushes it into the downstream FIFO in the same cycle. It holds a grant for up to MAX_BURST items, then releases it and rotates priority. Sits between the per-port input FIFOs and the shared output FIFO.

---
 rtl/fifo_rr_arbiter.sv | 152 +++++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// Round-robin burst scheduler: moves up to MAX_BURST items per grant from one of
// N upstream FIFOs into a shared downstream FIFO, one item per cycle.
module fifo_rr_arbiter #(
    parameter int N         = 4,
    parameter int SIZE      = 2,
    parameter int MAX_BURST = 4,
    parameter int routerid  = -1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        in_empty,
    input  logic [N*SIZE-1:0]   in_item,
    output logic [N-1:0]        in_read,
    input  logic                out_full,
    output logic [SIZE-1:0]     out_item,
    output logic                out_write,
    output logic [N-1:0]        grant,
    output logic                busy
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
    localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [N-1:0]    grant_r, grant_s;
    logic [IW-1:0]   last_r,  last_s;
    logic [CW-1:0]   cnt_r,   cnt_s;
    logic            busy_r,  busy_s;
    logic [IW-1:0]   pick_s;
    logic [IW-1:0]   idx_s;
    logic            found_s;
    logic            src_empty_s;
    logic            xfer_s;
    logic            release_s;
    logic [SIZE-1:0] items_s [N];

    // routerid only tags instances in simulation; it has no hardware effect.
    if (routerid < -1) begin : g_routerid_tag
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign items_s[gi] = in_item[gi*SIZE +: SIZE];
    end

    assign grant = grant_r;
    assign busy  = busy_r;

    // Rotating search: first non-empty source strictly after the last winner.
    always_comb begin
        pick_s  = last_r;
        found_s = 1'b0;
        idx_s   = last_r;
        for (int k = 1; k <= N; k++) begin
            idx_s = IW'((int'(last_r) + k) % N);
            if (!found_s && !in_empty[idx_s]) begin
                pick_s  = idx_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Transfer and release conditions for the granted source; reset gates pops.
    always_comb begin
        src_empty_s = in_empty[last_r];
        xfer_s      = reset & (state_r == BUSY) & ~src_empty_s & ~out_full;
        release_s   = (state_r == BUSY) & ((xfer_s & (cnt_r == CNT_LAST)) | src_empty_s);
    end

    // Zero-latency datapath from the granted upstream head to the downstream push.
    always_comb begin
        in_read   = {N{1'b0}};
        out_write = 1'b0;
        out_item  = {SIZE{1'b0}};
        if (state_r == BUSY) begin
            out_item = items_s[last_r];
        end else begin
            out_item = {SIZE{1'b0}};
        end
        if (xfer_s) begin
            in_read   = ONE_N << last_r;
            out_write = 1'b1;
        end else begin
            in_read   = {N{1'b0}};
            out_write = 1'b0;
        end
    end

    // Next-state logic: arbitrate in IDLE, count and release bursts in BUSY.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        last_s  = last_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_s = BUSY;
                    grant_s = ONE_N << pick_s;
                    last_s  = pick_s;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = IDLE;
                    grant_s = {N{1'b0}};
                end
            end
            BUSY: begin
                if (release_s) begin
                    state_s = IDLE;
                    grant_s = {N{1'b0}};
                    cnt_s   = {CW{1'b0}};
                end else if (xfer_s) begin
                    cnt_s = cnt_r + CW'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
                grant_s = {N{1'b0}};
                cnt_s   = {CW{1'b0}};
            end
        endcase
        busy_s = (state_s == BUSY);
    end

    // State register; last restarts at N-1 so input 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            grant_r <= {N{1'b0}};
            last_r  <= LAST_RST;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            last_r  <= last_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench for fifo_rr_arbiter: model upstream FIFOs feed the DUT and the
// expected (source, item) order is queued as stimulus is loaded.
module tb_fifo_rr_arbiter;
    localparam int N     = 4;
    localparam int SIZE  = 2;
    localparam int MB    = 4;
    localparam int DEPTH = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      in_empty;
    logic [N*SIZE-1:0] in_item;
    logic [N-1:0]      in_read;
    logic              out_full;
    logic [SIZE-1:0]   out_item;
    logic              out_write;
    logic [N-1:0]      grant;
    logic              busy;

    logic [SIZE-1:0] mem [N][DEPTH];
    int              rd_ptr [N];
    int              wr_ptr [N];
    int              exp_ptr [N];
    logic [5:0]      exp_q [$];
    int              dcyc [256];
    int              n_checks = 0;
    int              n_errors = 0;
    int              n_deliv  = 0;
    int              cyc      = 0;
    int              t0;
    int              base;
    int              b;

    fifo_rr_arbiter #(.N(N), .SIZE(SIZE), .MAX_BURST(MB), .routerid(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_empty  (in_empty),
        .in_item   (in_item),
        .in_read   (in_read),
        .out_full  (out_full),
        .out_item  (out_item),
        .out_write (out_write),
        .grant     (grant),
        .busy      (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            in_empty[i] = (rd_ptr[i] == wr_ptr[i]);
            in_item[i*SIZE +: SIZE] = in_empty[i] ? 2'b00 : mem[i][rd_ptr[i]];
        end
    endtask

    task automatic load(input int src, input logic [SIZE-1:0] val);
        mem[src][wr_ptr[src]] = val;
        wr_ptr[src]++;
    endtask

    task automatic load_rand(input int src, input int n);
        for (int k = 0; k < n; k++) load(src, 2'($urandom_range(0, 3)));
    endtask

    task automatic expect_next(input int src, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({4'(src), mem[src][exp_ptr[src]]});
            exp_ptr[src]++;
        end
    endtask

    // One clock cycle: sample combinational outputs at negedge, then pop the model FIFOs.
    task automatic tick();
        logic [N-1:0]    obs_read;
        logic            obs_write;
        logic [SIZE-1:0] obs_item;
        logic [3:0]      obs_src;
        logic [5:0]      e;
        @(negedge clk);
        obs_read  = in_read;
        obs_write = out_write;
        obs_item  = out_item;
        obs_src   = 4'd0;
        for (int i = 0; i < N; i++) if (obs_read[i]) obs_src = 4'(i);
        check_eq("rd_vs_wr", 32'(obs_read != 4'b0000), 32'(obs_write));
        check_eq("rd_onehot", 32'($countones(obs_read) <= 1), 32'd1);
        if (!reset) begin
            check_eq("rst_no_pop", 32'(obs_read), 32'd0);
            check_eq("rst_no_push", 32'(obs_write), 32'd0);
        end
        if (out_full) check_eq("full_no_pop", 32'(obs_read), 32'd0);
        if (!busy) begin
            check_eq("idle_no_pop", 32'(obs_read), 32'd0);
            check_eq("idle_item", 32'(obs_item), 32'd0);
        end
        if (obs_write) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 32'(obs_write), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("src", 32'(obs_src), 32'(e[5:2]));
                check_eq("item", 32'(obs_item), 32'(e[1:0]));
                check_eq("rd_is_grant", 32'(obs_read), 32'(grant));
                dcyc[n_deliv] = cyc;
                n_deliv++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (obs_read[i]) rd_ptr[i]++;
        drive_inputs();
    endtask

    task automatic wait_deliv(input int target, input int budget);
        int bb;
        bb = budget;
        while (n_deliv < target && bb > 0) begin
            tick();
            bb--;
        end
        check_eq("deliv_count", 32'(n_deliv), 32'(target));
    endtask

    task automatic drain(input int budget);
        int bb;
        bb = budget;
        while (exp_q.size() != 0 && bb > 0) begin
            tick();
            bb--;
        end
        check_eq("drained", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
        check_eq("idle_grant", 32'(grant), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
    endtask

    // Directed scenarios; expected transfer order is queued before each one runs.
    initial begin
        reset    = 1'b0;
        out_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            rd_ptr[i]  = 0;
            wr_ptr[i]  = 0;
            exp_ptr[i] = 0;
        end

        // Reset with every source full, then round robin 0,1,2,3,0,... in bursts of 4.
        for (int i = 0; i < N; i++) load_rand(i, 8);
        for (int r = 0; r < 2; r++) for (int s = 0; s < N; s++) expect_next(s, MB);
        drive_inputs();
        tick();
        tick();
        reset = 1'b1;
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        tick();
        check_eq("first_grant", 32'(grant), 32'h1);
        check_eq("first_busy", 32'(busy), 32'd1);
        t0 = cyc;
        wait_deliv(16, 40);
        check_eq("rr_16_in_20", 32'(dcyc[15] - t0), 32'd18);
        drain(60);

        // Short burst from FIFO 2 holding 1,3.
        load(2, 2'd1);
        load(2, 2'd3);
        expect_next(2, 2);
        drive_inputs();
        base = n_deliv;
        wait_deliv(base + 2, 10);
        check_eq("short_consecutive", 32'(dcyc[base+1] - dcyc[base]), 32'd1);
        check_eq("short_hold_grant", 32'(grant), 32'h4);
        check_eq("short_hold_busy", 32'(busy), 32'd1);
        tick();
        check_eq("short_rel_grant", 32'(grant), 32'd0);
        check_eq("short_rel_busy", 32'(busy), 32'd0);
        drain(10);

        // Backpressure for 5 cycles after the second transfer of a burst.
        load_rand(0, 6);
        expect_next(0, 6);
        drive_inputs();
        base = n_deliv;
        wait_deliv(base + 2, 10);
        out_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_eq("stall_grant", 32'(grant), 32'h1);
            check_eq("stall_busy", 32'(busy), 32'd1);
            tick();
        end
        out_full = 1'b0;
        b = 20;
        while (grant == 4'b0001 && b > 0) begin
            tick();
            b--;
        end
        check_eq("burst_total", 32'(n_deliv - base), 32'(MB));
        drain(30);

        // Reset during the third transfer; next grant must restart at input 0.
        load_rand(1, 6);
        load_rand(0, 4);
        load_rand(2, 4);
        expect_next(1, 2);
        expect_next(0, 4);
        expect_next(1, 4);
        expect_next(2, 4);
        drive_inputs();
        base = n_deliv;
        wait_deliv(base + 2, 10);
        reset = 1'b0;
        tick();
        check_eq("midrst_grant", 32'(grant), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();
        check_eq("post_rst_grant", 32'(grant), 32'h1);
        drain(60);

        // Wrap and skip: last=3, only FIFO 1 has data.
        load_rand(3, 1);
        expect_next(3, 1);
        drive_inputs();
        drain(10);
        load_rand(1, 2);
        expect_next(1, 2);
        drive_inputs();
        check_eq("wrap_pre_grant", 32'(grant), 32'd0);
        tick();
        check_eq("wrap_grant", 32'(grant), 32'h2);
        drain(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
